// File: rtl/uart_byte_sorter_pkg.sv
// ----------------------------------------------------------------------------
// uart_byte_sorter_pkg
//   Shared definitions for the UART byte sorter: byte width, the legal range
//   of the frame size, and the controller state encoding
//   (COLLECT=0, SORT=1, TX_LOAD=2, TX_WAIT=3).
//   Imported by uart_byte_sorter and sort_cmp_swap.
// ----------------------------------------------------------------------------
package uart_byte_sorter_pkg;

  localparam int BYTE_W        = 8;
  localparam int NUM_BYTES_MIN = 2;
  localparam int NUM_BYTES_MAX = 64;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SORT    = 2'd1,
    ST_TX_LOAD = 2'd2,
    ST_TX_WAIT = 2'd3
  } sort_state_e;

endpackage

// File: rtl/sort_cmp_swap.sv
// ----------------------------------------------------------------------------
// sort_cmp_swap
//   Combinational compare-and-swap cell for the bubble sort. The sort order
//   lives here and nowhere else.
//   Build option: SORT_DESCENDING_EN -- when defined, the larger byte is
//   placed first (descending order); otherwise the smaller byte is placed
//   first (ascending order). Equal bytes are never swapped.
//
//   Ports:
//     a, b       in   byte at position j and byte at position j+1
//     lo         out  byte to place at position j
//     hi         out  byte to place at position j+1
//     swap_flag  out  1 when a and b are out of order and get exchanged
// ----------------------------------------------------------------------------
module sort_cmp_swap
  import uart_byte_sorter_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  output logic [BYTE_W-1:0] lo,
  output logic [BYTE_W-1:0] hi,
  output logic              swap_flag
);

`ifdef SORT_DESCENDING_EN
  assign swap_flag = (a < b);
`else
  assign swap_flag = (a > b);
`endif

  assign lo = swap_flag ? b : a;
  assign hi = swap_flag ? a : b;

endmodule

// File: rtl/uart_byte_sorter.sv
// ----------------------------------------------------------------------------
// uart_byte_sorter
//   Sits between uart_rx and uart_tx. Collects NUM_BYTES received bytes,
//   bubble-sorts them in place (one compare per clock, early exit on a pass
//   without swaps), then sends the sorted bytes to the transmitter one at a
//   time, waiting for each stop bit before loading the next byte.
//   Build option: SORT_DESCENDING_EN (see sort_cmp_swap) flips the order.
//
//   Handshakes:
//     Rx side: i_Rx_DV is a one-cycle valid pulse with no back-pressure; a
//       byte presented while not in COLLECT is dropped and o_Overrun sticks.
//     Tx side: o_Tx_DV is a one-cycle request with o_Tx_Byte valid in the
//       same cycle; o_Tx_Byte then holds until i_Tx_Done, a one-cycle pulse
//       that is only honoured in TX_WAIT.
//
//   Ports:
//     i_Clock      in   system clock, rising edge
//     i_Rst_n      in   asynchronous active-low reset
//     i_Rx_DV      in   received byte valid pulse
//     i_Rx_Byte    in   received byte
//     i_Tx_Done    in   transmitter finished the stop bit
//     o_Tx_DV      out  transmit request pulse
//     o_Tx_Byte    out  byte to transmit
//     o_Busy       out  high in SORT, TX_LOAD and TX_WAIT
//     o_Overrun    out  sticky: an Rx byte was dropped
//     o_Frame_Cnt  out  completed frames, wraps 255->0
//     o_Dbg_State  out  current controller state (sort_state_e encoding)
// ----------------------------------------------------------------------------
module uart_byte_sorter
  import uart_byte_sorter_pkg::*;
#(
  parameter  int NUM_BYTES = 8,
  localparam int IDX_W     = $clog2(NUM_BYTES)
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic              i_Rx_DV,
  input  logic [BYTE_W-1:0] i_Rx_Byte,
  input  logic              i_Tx_Done,
  output logic              o_Tx_DV,
  output logic [BYTE_W-1:0] o_Tx_Byte,
  output logic              o_Busy,
  output logic              o_Overrun,
  output logic [7:0]        o_Frame_Cnt,
  output logic [1:0]        o_Dbg_State
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BYTES - 1);
  localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(NUM_BYTES - 2);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  sort_state_e       state_q,     state_d;
  logic [IDX_W-1:0]  wr_idx_q,    wr_idx_d;
  logic [IDX_W-1:0]  pass_q,      pass_d;
  logic [IDX_W-1:0]  j_q,         j_d;
  logic [IDX_W-1:0]  tx_idx_q,    tx_idx_d;
  logic              swapped_q,   swapped_d;
  logic              overrun_q,   overrun_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic [BYTE_W-1:0] tx_byte_q,   tx_byte_d;
  logic [BYTE_W-1:0] mem_q [NUM_BYTES];
  logic [BYTE_W-1:0] mem_d [NUM_BYTES];

  logic [IDX_W-1:0]  j_nxt;
  logic [IDX_W-1:0]  j_last;
  logic [BYTE_W-1:0] cmp_lo;
  logic [BYTE_W-1:0] cmp_hi;
  logic              cmp_swap;

  // j never exceeds NUM_BYTES-2, so j+1 always addresses a real entry.
  assign j_nxt  = j_q + IDX_ONE;
  // Each pass bubbles one more element into its final place, so the last
  // compare position shrinks by one per pass.
  assign j_last = LAST_PASS - pass_q;

  sort_cmp_swap u_cmp (
    .a         (mem_q[j_q]),
    .b         (mem_q[j_nxt]),
    .lo        (cmp_lo),
    .hi        (cmp_hi),
    .swap_flag (cmp_swap)
  );

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    pass_d      = pass_q;
    j_d         = j_q;
    tx_idx_d    = tx_idx_q;
    swapped_d   = swapped_q;
    overrun_d   = overrun_q;
    frame_cnt_d = frame_cnt_q;
    tx_byte_d   = tx_byte_q;
    mem_d       = mem_q;

    // No back-pressure toward uart_rx: anything arriving outside COLLECT is
    // lost, including in the cycle the final i_Tx_Done is accepted.
    if (i_Rx_DV && (state_q != ST_COLLECT)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_COLLECT: begin
        if (i_Rx_DV) begin
          mem_d[wr_idx_q] = i_Rx_Byte;
          if (wr_idx_q == LAST_IDX) begin
            state_d   = ST_SORT;
            pass_d    = '0;
            j_d       = '0;
            swapped_d = 1'b0;
          end else begin
            wr_idx_d = wr_idx_q + IDX_ONE;
          end
        end
      end

      ST_SORT: begin
        if (cmp_swap) begin
          mem_d[j_q]   = cmp_lo;
          mem_d[j_nxt] = cmp_hi;
          swapped_d    = 1'b1;
        end
        if (j_q < j_last) begin
          j_d = j_nxt;
        end else if (!(swapped_q || cmp_swap) || (pass_q == LAST_PASS)) begin
          // A clean pass means the frame is ordered; the last pass only
          // compares positions 0 and 1, so nothing can remain after it.
          state_d  = ST_TX_LOAD;
          tx_idx_d = '0;
        end else begin
          pass_d    = pass_q + IDX_ONE;
          j_d       = '0;
          swapped_d = 1'b0;
        end
      end

      ST_TX_LOAD: begin
        tx_byte_d = mem_q[tx_idx_q];
        state_d   = ST_TX_WAIT;
      end

      ST_TX_WAIT: begin
        if (i_Tx_Done) begin
          if (tx_idx_q == LAST_IDX) begin
            tx_idx_d    = '0;
            wr_idx_d    = '0;
            frame_cnt_d = frame_cnt_q + 8'd1;
            state_d     = ST_COLLECT;
          end else begin
            tx_idx_d = tx_idx_q + IDX_ONE;
            state_d  = ST_TX_LOAD;
          end
        end
      end

      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= ST_COLLECT;
      wr_idx_q    <= '0;
      pass_q      <= '0;
      j_q         <= '0;
      tx_idx_q    <= '0;
      swapped_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
      tx_byte_q   <= '0;
      for (int k = 0; k < NUM_BYTES; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      pass_q      <= pass_d;
      j_q         <= j_d;
      tx_idx_q    <= tx_idx_d;
      swapped_q   <= swapped_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
      tx_byte_q   <= tx_byte_d;
      mem_q       <= mem_d;
    end
  end

  // The byte is presented straight from the array during TX_LOAD so it is
  // valid together with o_Tx_DV; the register then holds it through TX_WAIT
  // and beyond, until the next load.
  assign o_Tx_DV     = (state_q == ST_TX_LOAD);
  assign o_Tx_Byte   = (state_q == ST_TX_LOAD) ? mem_q[tx_idx_q] : tx_byte_q;
  assign o_Busy      = (state_q != ST_COLLECT);
  assign o_Overrun   = overrun_q;
  assign o_Frame_Cnt = frame_cnt_q;
  assign o_Dbg_State = state_q;

endmodule

// File: tb/tb_uart_byte_sorter.sv
// ----------------------------------------------------------------------------
// tb_uart_byte_sorter
//   Self-checking bench for uart_byte_sorter (NUM_BYTES = 8). Plays both the
//   uart_rx side (byte pulses) and the uart_tx side (done pulses after a
//   random delay). Expected bytes and sort latency come from constant tables
//   and from a reference model that sorts with a queue and derives the pass
//   count from how far each byte has to travel.
//   Honours SORT_DESCENDING_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_uart_byte_sorter;

  localparam int NB = 8;

  typedef logic [0:NB-1][7:0] frame_t;
  typedef struct packed {
    frame_t     din;
    frame_t     dout;
    logic [7:0] cyc;
  } vec_t;

  // ---------------------------------------------------------------- clock/reset
  logic       clk = 1'b0;
  logic       i_Rst_n = 1'b0;
  logic       i_Rx_DV = 1'b0;
  logic [7:0] i_Rx_Byte = 8'h00;
  logic       i_Tx_Done = 1'b0;
  logic       o_Tx_DV;
  logic [7:0] o_Tx_Byte;
  logic       o_Busy;
  logic       o_Overrun;
  logic [7:0] o_Frame_Cnt;
  logic [1:0] o_Dbg_State;

  always #5 clk = ~clk;

  uart_byte_sorter #(.NUM_BYTES(NB)) dut (
    .i_Clock     (clk),
    .i_Rst_n     (i_Rst_n),
    .i_Rx_DV     (i_Rx_DV),
    .i_Rx_Byte   (i_Rx_Byte),
    .i_Tx_Done   (i_Tx_Done),
    .o_Tx_DV     (o_Tx_DV),
    .o_Tx_Byte   (o_Tx_Byte),
    .o_Busy      (o_Busy),
    .o_Overrun   (o_Overrun),
    .o_Frame_Cnt (o_Frame_Cnt),
    .o_Dbg_State (o_Dbg_State)
  );

  // ---------------------------------------------------------------- scoreboard
  int         total = 0;
  int         bad = 0;
  int         exp_frames = 0;
  logic       exp_overrun = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: sorted values from a queue sort; latency from the fact that a
  // bubble pass moves every out-of-place byte one step toward the front, so
  // the passes needed are (largest count of out-of-order predecessors) + 1
  // clean pass, capped at NB-1 passes, and pass p costs NB-1-p compares.
  function automatic void model_sort(input frame_t d, output frame_t s, output int cyc);
    logic [7:0] q[$];
    int maxmv;
    int mv;
    int passes;
    q = {};
    for (int i = 0; i < NB; i++) q.push_back(d[i]);
`ifdef SORT_DESCENDING_EN
    q.rsort();
`else
    q.sort();
`endif
    for (int i = 0; i < NB; i++) s[i] = q[i];
    maxmv = 0;
    for (int i = 0; i < NB; i++) begin
      mv = 0;
      for (int k = 0; k < i; k++) begin
`ifdef SORT_DESCENDING_EN
        if (d[k] < d[i]) mv++;
`else
        if (d[k] > d[i]) mv++;
`endif
      end
      if (mv > maxmv) maxmv = mv;
    end
    passes = (maxmv + 1 > NB - 1) ? NB - 1 : maxmv + 1;
    cyc = 0;
    for (int p = 0; p < passes; p++) cyc += NB - 1 - p;
  endfunction

  // ---------------------------------------------------------------- drivers
  // All drivers start and end on a falling edge.
  task automatic send_frame(input frame_t d);
    for (int i = 0; i < NB; i++) begin
      i_Rx_DV   = 1'b1;
      i_Rx_Byte = d[i];
      @(negedge clk);
      i_Rx_DV   = 1'b0;
      i_Rx_Byte = 8'h00;
      if (i < NB - 1) begin
        // Stray done pulses while collecting must be ignored.
        repeat ($urandom_range(0, 2)) begin
          i_Tx_Done = ($urandom_range(0, 3) == 0);
          @(negedge clk);
          i_Tx_Done = 1'b0;
        end
      end
    end
  endtask

  // Counts busy cycles before the first transmit request (the SORT phase).
  task automatic measure_sort(input bit inj, output int cyc);
    cyc = 0;
    for (int t = 0; t < 200 && !o_Tx_DV; t++) begin
      if (o_Busy) cyc++;
      i_Rx_DV   = inj && (cyc == 3);
      i_Rx_Byte = 8'h55;
      @(negedge clk);
    end
    i_Rx_DV   = 1'b0;
    i_Rx_Byte = 8'h00;
    if (!o_Tx_DV) check("sort_timeout", 0, 1);
  endtask

  // Acts as uart_tx for the first n bytes of the frame.
  task automatic collect_tx(input frame_t exp, input int n, input bit inj_mid, input bit inj_last);
    int w;
    for (int i = 0; i < n; i++) begin
      for (int t = 0; t < 200 && !o_Tx_DV; t++) @(negedge clk);
      if (!o_Tx_DV) begin
        check("tx_dv_timeout", 0, 1);
        return;
      end
      check("tx_byte", o_Tx_Byte, exp[i]);
      @(negedge clk);
      check("tx_dv_one_cycle", o_Tx_DV, 0);
      w = $urandom_range(1, 3);
      for (int k = 0; k < w; k++) begin
        i_Rx_DV   = inj_mid && (i == 2) && (k == 0);
        i_Rx_Byte = 8'h55;
        @(negedge clk);
        i_Rx_DV   = 1'b0;
        check("tx_byte_hold", o_Tx_Byte, exp[i]);
      end
      i_Tx_Done = 1'b1;
      i_Rx_DV   = inj_last && (i == NB - 1);
      i_Rx_Byte = 8'h55;
      @(negedge clk);
      i_Tx_Done = 1'b0;
      i_Rx_DV   = 1'b0;
      i_Rx_Byte = 8'h00;
    end
  endtask

  task automatic run_frame(input frame_t din, input frame_t exp, input int exp_cyc,
                           input bit inj_sort, input bit inj_mid, input bit inj_last);
    int cyc;
    send_frame(din);
    measure_sort(inj_sort, cyc);
    check("sort_cycles", cyc, exp_cyc);
    collect_tx(exp, NB, inj_mid, inj_last);
    if (inj_sort || inj_mid || inj_last) exp_overrun = 1'b1;
    exp_frames = (exp_frames + 1) % 256;
    check("frame_cnt", o_Frame_Cnt, exp_frames);
    check("busy_after_frame", o_Busy, 0);
    check("overrun", o_Overrun, exp_overrun);
  endtask

  // ---------------------------------------------------------------- stimulus
  vec_t   tbl[3];
  frame_t rnd;
  frame_t rexp;
  int     rcyc;

  initial begin
    tbl[0] = '{din:  {8'h07, 8'h03, 8'h05, 8'h01, 8'h08, 8'h02, 8'h06, 8'h04},
`ifdef SORT_DESCENDING_EN
               dout: {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01},
`else
               dout: {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08},
`endif
               cyc:  8'd25};
    tbl[1] = '{din:  {8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80},
`ifdef SORT_DESCENDING_EN
               dout: {8'h80, 8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10},
               cyc:  8'd28};
`else
               dout: {8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80},
               cyc:  8'd7};
`endif
    tbl[2] = '{din:  {8'h3F, 8'h3F, 8'h00, 8'hFF, 8'h3F, 8'h00, 8'hAB, 8'hAB},
`ifdef SORT_DESCENDING_EN
               dout: {8'hFF, 8'hAB, 8'hAB, 8'h3F, 8'h3F, 8'h3F, 8'h00, 8'h00},
               cyc:  8'd27};
`else
               dout: {8'h00, 8'h00, 8'h3F, 8'h3F, 8'h3F, 8'hAB, 8'hAB, 8'hFF},
               cyc:  8'd25};
`endif

    // Reset state, checked while reset is held.
    repeat (3) @(negedge clk);
    check("rst_tx_dv", o_Tx_DV, 0);
    check("rst_tx_byte", o_Tx_Byte, 0);
    check("rst_busy", o_Busy, 0);
    check("rst_overrun", o_Overrun, 0);
    check("rst_frame_cnt", o_Frame_Cnt, 0);
    i_Rst_n = 1'b1;
    @(negedge clk);

    // Table vectors.
    for (int v = 0; v < 3; v++) begin
      run_frame(tbl[v].din, tbl[v].dout, int'(tbl[v].cyc), 1'b0, 1'b0, 1'b0);
    end

    // Dropped bytes during SORT and TX_WAIT, then a clean frame.
    run_frame(tbl[0].din, tbl[0].dout, int'(tbl[0].cyc), 1'b1, 1'b1, 1'b0);
    run_frame(tbl[2].din, tbl[2].dout, int'(tbl[2].cyc), 1'b0, 1'b0, 1'b0);

    // Random frames against the reference model; some with a narrow value
    // range so duplicates are common.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NB; i++) begin
        rnd[i] = (f % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
      end
      model_sort(rnd, rexp, rcyc);
      exp_q = {};
      for (int i = 0; i < NB; i++) exp_q.push_back(rexp[i]);
      check("model_len", exp_q.size(), NB);
      run_frame(rnd, rexp, rcyc, 1'b0, 1'b0, 1'b0);
    end

    // Reset while waiting for the stop bit of the fourth byte.
    begin
      int cyc;
      send_frame(tbl[0].din);
      measure_sort(1'b0, cyc);
      collect_tx(tbl[0].dout, 3, 1'b0, 1'b0);
      for (int t = 0; t < 200 && !o_Tx_DV; t++) @(negedge clk);
      check("byte4_dv", o_Tx_DV, 1);
      check("byte4_value", o_Tx_Byte, tbl[0].dout[3]);
      @(negedge clk);
      #2;
      i_Rst_n = 1'b0;
      #1;
      check("async_rst_tx_dv", o_Tx_DV, 0);
      check("async_rst_tx_byte", o_Tx_Byte, 0);
      check("async_rst_busy", o_Busy, 0);
      check("async_rst_overrun", o_Overrun, 0);
      check("async_rst_frame_cnt", o_Frame_Cnt, 0);
      @(negedge clk);
      i_Rst_n = 1'b1;
      exp_frames  = 0;
      exp_overrun = 1'b0;
      @(negedge clk);
      check("post_rst_idle", o_Busy, 0);
      run_frame(tbl[0].din, tbl[0].dout, int'(tbl[0].cyc), 1'b0, 1'b0, 1'b0);
    end

    // A byte arriving in the same cycle as the final done is still dropped.
    run_frame(tbl[1].din, tbl[1].dout, int'(tbl[1].cyc), 1'b0, 1'b0, 1'b1);
    run_frame(tbl[2].din, tbl[2].dout, int'(tbl[2].cyc), 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------------------------------------------------------- watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
